// File: rtl/spi_tx_fifo_if.sv
// spi_tx_fifo_if: user write side and spi_drive side of the TX FIFO.
// Ports: i_wr_data/i_wr_en (enqueue), o_full/o_almost_full/o_empty/o_level
// (status), o_user_data/o_user_valid/i_ready (head handshake to spi_drive).
// Modports: slave = FIFO view, master = user/driver view.
interface spi_tx_fifo_if #(
    parameter int P_DATA_WIDTH = 9,
    parameter int P_ADDR_WIDTH = 4
);
    logic [P_DATA_WIDTH-1:0] i_wr_data;
    logic                    i_wr_en;
    logic                    o_full;
    logic                    o_almost_full;
    logic                    o_empty;
    logic [P_ADDR_WIDTH:0]   o_level;
    logic [P_DATA_WIDTH-1:0] o_user_data;
    logic                    o_user_valid;
    logic                    i_ready;

    modport slave (
        input  i_wr_data, i_wr_en, i_ready,
        output o_full, o_almost_full, o_empty, o_level,
        output o_user_data, o_user_valid
    );

    modport master (
        output i_wr_data, i_wr_en, i_ready,
        input  o_full, o_almost_full, o_empty, o_level,
        input  o_user_data, o_user_valid
    );
endinterface

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: buffers user words and feeds spi_drive one word at a time,
// forcing P_GAP_CYCLES valid-low cycles after each accepted word.
// Ports: i_clk, i_rst (async, active-high), bus (spi_tx_fifo_if.slave).
// Option SPI_TX_FIFO_STATUS_EN: adds o_overflow (sticky) and i_flush.
module spi_tx_fifo #(
    parameter int P_DATA_WIDTH  = 9,
    parameter int P_DEPTH       = 16,
    parameter int P_ADDR_WIDTH  = 4,
    parameter int P_ALMOST_FULL = 12,
    parameter int P_GAP_CYCLES  = 2
) (
    input  logic i_clk,
    input  logic i_rst,
`ifdef SPI_TX_FIFO_STATUS_EN
    input  logic i_flush,
    output logic o_overflow,
`endif
    spi_tx_fifo_if.slave bus
);
    localparam int LW = P_ADDR_WIDTH + 1;
    localparam int GW = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
    localparam int GAP_INIT = (P_GAP_CYCLES > 0) ? P_GAP_CYCLES - 1 : 0;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_INIT);
    localparam logic [LW-1:0] DEPTH_L = LW'(P_DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(P_ALMOST_FULL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t state;

    logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
    logic [P_ADDR_WIDTH-1:0] wr_ptr;
    logic [P_ADDR_WIDTH-1:0] rd_ptr;
    logic [GW-1:0]           gap_cnt;

    logic          flush;
    logic          accept;
    logic          wr_ok;
    logic          head_full;
    logic          need_head;
    logic          load_ram;
    logic          load_byp;
    logic          mem_we;
    logic [LW-1:0] ram_cnt;
    logic [LW-1:0] level_nxt;

`ifdef SPI_TX_FIFO_STATUS_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign accept    = bus.o_user_valid & bus.i_ready;
    assign wr_ok     = bus.i_wr_en & ~bus.o_full & ~flush;
    assign head_full = (state == S_PRESENT);
    // Level counts the head register too; RAM holds the rest.
    assign ram_cnt   = bus.o_level - LW'(head_full);

    always_comb begin
        need_head = 1'b0;
        unique case (state)
            S_IDLE:    need_head = 1'b1;
            S_PRESENT: need_head = accept && (P_GAP_CYCLES == 0);
            S_GAP:     need_head = (gap_cnt == '0);
            default:   need_head = 1'b0;
        endcase
    end

    // An incoming word skips the RAM only when the RAM has nothing
    // older to hand over, which keeps ordering intact.
    assign load_ram = need_head & (ram_cnt != '0);
    assign load_byp = need_head & (ram_cnt == '0) & wr_ok;
    assign mem_we   = wr_ok & ~load_byp;

    always_comb begin
        level_nxt = bus.o_level + LW'(wr_ok) - LW'(accept);
        if (flush) begin
            level_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            gap_cnt           <= '0;
            bus.o_level       <= '0;
            bus.o_full        <= 1'b0;
            bus.o_almost_full <= 1'b0;
            bus.o_empty       <= 1'b1;
            bus.o_user_data   <= '0;
            bus.o_user_valid  <= 1'b0;
        end else if (flush) begin
            state             <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            gap_cnt           <= '0;
            bus.o_level       <= '0;
            bus.o_full        <= 1'b0;
            bus.o_almost_full <= 1'b0;
            bus.o_empty       <= 1'b1;
            bus.o_user_data   <= '0;
            bus.o_user_valid  <= 1'b0;
        end else begin
            bus.o_level       <= level_nxt;
            bus.o_full        <= (level_nxt == DEPTH_L);
            bus.o_almost_full <= (level_nxt >= AFULL_L);
            bus.o_empty       <= (level_nxt == '0);

            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_ram) begin
                rd_ptr          <= rd_ptr + 1'b1;
                bus.o_user_data <= mem[rd_ptr];
            end else if (load_byp) begin
                bus.o_user_data <= bus.i_wr_data;
            end

            unique case (state)
                S_IDLE: begin
                    if (load_ram || load_byp) begin
                        state            <= S_PRESENT;
                        bus.o_user_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (accept) begin
                        if (P_GAP_CYCLES > 0) begin
                            state            <= S_GAP;
                            gap_cnt          <= GAP_LOAD;
                            bus.o_user_valid <= 1'b0;
                        end else if (load_ram || load_byp) begin
                            state            <= S_PRESENT;
                            bus.o_user_valid <= 1'b1;
                        end else begin
                            state            <= S_IDLE;
                            bus.o_user_valid <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        if (load_ram || load_byp) begin
                            state            <= S_PRESENT;
                            bus.o_user_valid <= 1'b1;
                        end else begin
                            state            <= S_IDLE;
                            bus.o_user_valid <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state            <= S_IDLE;
                    bus.o_user_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_TX_FIFO_STATUS_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (bus.i_wr_en && bus.o_full) begin
            o_overflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_spi_tx_fifo.sv
// tb_spi_tx_fifo: scoreboard bench for spi_tx_fifo.
// Words are queued when written and checked when the DUT hands them over.
module tb_spi_tx_fifo;
    logic clk;
    logic rst;
    logic flush;
    logic overflow;

    spi_tx_fifo_if #(.P_DATA_WIDTH(9), .P_ADDR_WIDTH(4)) bus ();

    spi_tx_fifo dut (
        .i_clk      (clk),
        .i_rst      (rst),
`ifdef SPI_TX_FIFO_STATUS_EN
        .i_flush    (flush),
        .o_overflow (overflow),
`endif
        .bus        (bus)
    );

`ifndef SPI_TX_FIFO_STATUS_EN
    assign overflow = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int pops = 0;
    int low_run = 0;
    bit after_acc = 0;
    bit gap_on = 0;
    bit auto_on = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Clock step; the bench's own word count predicts level and flags.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_on) begin
            chk("level", 32'(bus.o_level), exp_q.size());
            chk("full", 32'(bus.o_full), 32'(exp_q.size() == 16));
            chk("afull", 32'(bus.o_almost_full), 32'(exp_q.size() >= 12));
            chk("empty", 32'(bus.o_empty), 32'(exp_q.size() == 0));
        end
    endtask

    task automatic put(input logic [8:0] d);
        bus.i_wr_data = d;
        bus.i_wr_en   = 1'b1;
        if (exp_q.size() < 16) begin
            exp_q.push_back(d);
        end
    endtask

    // Handover monitor: an accept happens at the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_user_valid) begin
                if (gap_on && after_acc) begin
                    chk("gap", low_run, 2);
                end
                after_acc = 0;
                if (bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 32'(bus.o_user_data), 32'h3ff);
                    end else begin
                        chk("data", 32'(bus.o_user_data), 32'(exp_q.pop_front()));
                    end
                    pops++;
                    after_acc = 1;
                    low_run = 0;
                end
            end else if (after_acc) begin
                low_run++;
            end
        end
    end

    initial begin
        int n;
        int p0;
        bit fill;

        rst           = 1'b1;
        flush         = 1'b0;
        bus.i_wr_data = '0;
        bus.i_wr_en   = 1'b0;
        bus.i_ready   = 1'b0;
        auto_on       = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(bus.o_user_valid), 0);
        chk("rst_data", 32'(bus.o_user_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b0;
        step();

        // Single word through an empty FIFO
        put(9'h088);
        step();
        bus.i_wr_en = 1'b0;
        chk("t2_valid", 32'(bus.o_user_valid), 1);
        chk("t2_data", 32'(bus.o_user_data), 32'h088);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("t2_gap1", 32'(bus.o_user_valid), 0);
        step();
        chk("t2_gap2", 32'(bus.o_user_valid), 0);
        step();
        chk("t2_idle", 32'(bus.o_user_valid), 0);
        chk("t2_empty", 32'(bus.o_empty), 1);

        // Burst to full, one dropped write, then drain
        for (int i = 1; i <= 16; i++) begin
            put(9'(i));
            step();
        end
        put(9'h1ff);
        step();
        bus.i_wr_en = 1'b0;
        chk("t3_full", 32'(bus.o_full), 1);
        chk("t3_level", 32'(bus.o_level), 16);
        gap_on = 1;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
            step();
        end
        bus.i_ready = 1'b0;
        gap_on = 0;
        chk("t3_left", exp_q.size(), 0);
        step();
        step();
        step();
        chk("t3_empty", 32'(bus.o_empty), 1);

        // Streaming across pointer wrap, level swinging 3..9
        n = 0;
        fill = 1;
        p0 = pops;
        bus.i_ready = 1'b1;
        for (int k = 0; k < 600 && (n < 40 || exp_q.size() > 0); k++) begin
            if (exp_q.size() >= 9) fill = 0;
            else if (exp_q.size() <= 3) fill = 1;
            if (n < 40 && fill) begin
                put(9'($urandom_range(0, 511)));
                n++;
            end else begin
                bus.i_wr_en = 1'b0;
            end
            step();
        end
        bus.i_wr_en = 1'b0;
        bus.i_ready = 1'b0;
        chk("t4_left", exp_q.size(), 0);
        chk("t4_pops", pops - p0, 40);
        step();
        step();
        step();

        // Write on the accept cycle with one word held
        put(9'h0aa);
        step();
        bus.i_wr_en = 1'b0;
        chk("t5_valid", 32'(bus.o_user_valid), 1);
        bus.i_ready = 1'b1;
        put(9'h055);
        step();
        bus.i_ready = 1'b0;
        bus.i_wr_en = 1'b0;
        chk("t5_level", 32'(bus.o_level), 1);
        step();
        step();
        chk("t5_valid2", 32'(bus.o_user_valid), 1);
        chk("t5_data", 32'(bus.o_user_data), 32'h055);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        step();
        step();
        step();

        // Asynchronous reset mid-stream
        put(9'h101);
        step();
        put(9'h102);
        step();
        put(9'h103);
        step();
        bus.i_wr_en = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t1_valid", 32'(bus.o_user_valid), 0);
        chk("t1_data", 32'(bus.o_user_data), 0);
        chk("t1_level", 32'(bus.o_level), 0);
        chk("t1_empty", 32'(bus.o_empty), 1);
        chk("t1_full", 32'(bus.o_full), 0);
        step();
        rst = 1'b0;
        step();

`ifdef SPI_TX_FIFO_STATUS_EN
        // Overflow flag and flush
        for (int i = 0; i < 16; i++) begin
            put(9'(9'h040 + i));
            step();
        end
        put(9'h1ff);
        step();
        bus.i_wr_en = 1'b0;
        chk("t6_ovf", 32'(overflow), 1);
        step();
        chk("t6_ovf_hold", 32'(overflow), 1);
        flush = 1'b1;
        bus.i_wr_data = 9'h077;
        bus.i_wr_en = 1'b1;
        exp_q.delete();
        step();
        flush = 1'b0;
        bus.i_wr_en = 1'b0;
        chk("t6_flush_level", 32'(bus.o_level), 0);
        chk("t6_flush_valid", 32'(bus.o_user_valid), 0);
        chk("t6_ovf_sticky", 32'(overflow), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_ovf_clr", 32'(overflow), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
